// File: rtl/uart_rx_frame_counter.sv
// Oversampling edge/bit counter for the UART receiver: counts edges per bit
// against a latched prescale, emits centre-tap sample strobes and bit/frame pulses.
module uart_rx_frame_counter #(
    parameter int PRESCALE_W = 6,
    parameter int DATA_W     = 8,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Enable,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Par_En,
    input  logic                  Stop2,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic                  sample_stb,
    output logic [1:0]            sample_idx,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  Busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [PRESCALE_W-1:0] P_MIN  = PRESCALE_W'(4);
    localparam logic [PRESCALE_W-1:0] P_ONE  = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  B_ONE  = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0]  N_BASE = BIT_CNT_W'(DATA_W + 2);

    logic [1:0]            r_state;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [BIT_CNT_W-1:0]  r_numBits;
    logic [PRESCALE_W-1:0] r_edge;
    logic [BIT_CNT_W-1:0]  r_bit;
    logic                  r_sampleStb;
    logic [1:0]            r_sampleIdx;
    logic                  r_bitDone;
    logic                  r_frameDone;
    logic                  r_busy;

    logic [1:0]            w_stateNxt;
    logic [PRESCALE_W-1:0] w_prescaleNxt;
    logic [BIT_CNT_W-1:0]  w_numBitsNxt;
    logic [PRESCALE_W-1:0] w_edgeNxt;
    logic [BIT_CNT_W-1:0]  w_bitNxt;
    logic [PRESCALE_W-1:0] w_prescaleIn;
    logic [BIT_CNT_W-1:0]  w_numBitsIn;
    logic                  w_lastEdge;
    logic                  w_lastBit;
    logic [PRESCALE_W-1:0] w_centre;
    logic                  w_stbNxt;
    logic [1:0]            w_idxNxt;
    logic                  w_bitDoneNxt;
    logic                  w_frameDoneNxt;
    logic                  w_busyNxt;

    // Oversample ratios below 4 cannot place three distinct centre taps, so clamp.
    assign w_prescaleIn = (Prescale < P_MIN) ? P_MIN : Prescale;
    assign w_numBitsIn  = N_BASE + BIT_CNT_W'(Par_En) + BIT_CNT_W'(Stop2);

    assign w_lastEdge = (r_edge == (r_prescale - P_ONE));
    assign w_lastBit  = (r_bit == (r_numBits - B_ONE));

    always_comb begin
        w_stateNxt    = r_state;
        w_prescaleNxt = r_prescale;
        w_numBitsNxt  = r_numBits;
        w_edgeNxt     = '0;
        w_bitNxt      = '0;
        case (r_state)
            S_IDLE: begin
                if (Enable) begin
                    w_stateNxt    = S_COUNT;
                    w_prescaleNxt = w_prescaleIn;
                    w_numBitsNxt  = w_numBitsIn;
                end
            end
            S_COUNT: begin
                if (!Enable) begin
                    w_stateNxt = S_IDLE;
                end else if (w_lastEdge && w_lastBit) begin
                    w_stateNxt = S_DONE;
                end else if (w_lastEdge) begin
                    w_bitNxt = r_bit + B_ONE;
                end else begin
                    w_edgeNxt = r_edge + P_ONE;
                    w_bitNxt  = r_bit;
                end
            end
            S_DONE: begin
                if (!Enable) begin
                    w_stateNxt = S_IDLE;
                end
            end
            default: begin
                w_stateNxt = S_IDLE;
            end
        endcase
    end

    // Strobes are derived from the next counter values so they line up with the registered counters.
    assign w_centre = w_prescaleNxt >> 1;
    assign w_busyNxt = (w_stateNxt == S_COUNT);

    always_comb begin
        w_stbNxt       = 1'b0;
        w_idxNxt       = 2'd0;
        w_bitDoneNxt   = 1'b0;
        w_frameDoneNxt = 1'b0;
        if (w_busyNxt) begin
            if (w_edgeNxt == (w_centre - P_ONE)) begin
                w_stbNxt = 1'b1;
                w_idxNxt = 2'd0;
            end else if (w_edgeNxt == w_centre) begin
                w_stbNxt = 1'b1;
                w_idxNxt = 2'd1;
            end else if (w_edgeNxt == (w_centre + P_ONE)) begin
                w_stbNxt = 1'b1;
                w_idxNxt = 2'd2;
            end
            w_bitDoneNxt   = (w_edgeNxt == (w_prescaleNxt - P_ONE));
            w_frameDoneNxt = w_bitDoneNxt && (w_bitNxt == (w_numBitsNxt - B_ONE));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_prescale  <= '0;
            r_numBits   <= '0;
            r_edge      <= '0;
            r_bit       <= '0;
            r_sampleStb <= 1'b0;
            r_sampleIdx <= 2'd0;
            r_bitDone   <= 1'b0;
            r_frameDone <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_stateNxt;
            r_prescale  <= w_prescaleNxt;
            r_numBits   <= w_numBitsNxt;
            r_edge      <= w_edgeNxt;
            r_bit       <= w_bitNxt;
            r_sampleStb <= w_stbNxt;
            r_sampleIdx <= w_idxNxt;
            r_bitDone   <= w_bitDoneNxt;
            r_frameDone <= w_frameDoneNxt;
            r_busy      <= w_busyNxt;
        end
    end

    assign edge_count = r_edge;
    assign bit_count  = r_bit;
    assign sample_stb = r_sampleStb;
    assign sample_idx = r_sampleIdx;
    assign bit_done   = r_bitDone;
    assign frame_done = r_frameDone;
    assign Busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Directed bench for uart_rx_frame_counter: a cycle-index model checked every
// cycle, plus hand-computed frame lengths and tap positions.
module tb_uart_rx_frame_counter;

    localparam int PRESCALE_W = 6;
    localparam int DATA_W     = 8;
    localparam int BIT_CNT_W  = 4;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  Enable;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  Par_En;
    logic                  Stop2;
    logic [PRESCALE_W-1:0] edge_count;
    logic [BIT_CNT_W-1:0]  bit_count;
    logic                  sample_stb;
    logic [1:0]            sample_idx;
    logic                  bit_done;
    logic                  frame_done;
    logic                  Busy;

    int checks = 0;
    int errors = 0;
    logic checkEn = 1'b0;

    // Model state: mode 0 idle, 1 counting, 2 done; mK is cycles since frame start.
    int mMode = 0;
    int mK = 0;
    int mP = 4;
    int mN = 10;
    int expEdge = 0, expBit = 0, expStb = 0, expIdx = 0, expBitDone = 0, expFrameDone = 0, expBusy = 0;

    uart_rx_frame_counter #(
        .PRESCALE_W(PRESCALE_W),
        .DATA_W    (DATA_W),
        .BIT_CNT_W (BIT_CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Enable    (Enable),
        .Prescale  (Prescale),
        .Par_En    (Par_En),
        .Stop2     (Stop2),
        .edge_count(edge_count),
        .bit_count (bit_count),
        .sample_stb(sample_stb),
        .sample_idx(sample_idx),
        .bit_done  (bit_done),
        .frame_done(frame_done),
        .Busy      (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame arithmetic: cycle k of a frame sits at edge k%P of bit k/P.
    always @(posedge CLK) begin
        int c, e;
        if (RST) begin
            mMode = 0;
        end else begin
            case (mMode)
                0: if (Enable) begin
                    mMode = 1;
                    mP = (int'(Prescale) < 4) ? 4 : int'(Prescale);
                    mN = 1 + DATA_W + int'(Par_En) + 1 + int'(Stop2);
                    mK = 0;
                end
                1: if (!Enable) mMode = 0;
                   else if (mK == mN * mP - 1) mMode = 2;
                   else mK++;
                default: if (!Enable) mMode = 0;
            endcase
        end
        expEdge = 0; expBit = 0; expStb = 0; expIdx = 0;
        expBitDone = 0; expFrameDone = 0; expBusy = 0;
        if (mMode == 1) begin
            e = mK % mP;
            c = mP / 2;
            expEdge = e;
            expBit = mK / mP;
            expStb = (e >= c - 1 && e <= c + 1) ? 1 : 0;
            expIdx = expStb ? e - (c - 1) : 0;
            expBitDone = (e == mP - 1) ? 1 : 0;
            expFrameDone = (mK == mN * mP - 1) ? 1 : 0;
            expBusy = 1;
        end
    end

    always @(negedge CLK) begin
        if (checkEn) begin
            checkOutput("edge_count", edge_count, expEdge);
            checkOutput("bit_count", bit_count, expBit);
            checkOutput("sample_stb", sample_stb, expStb);
            checkOutput("sample_idx", sample_idx, expIdx);
            checkOutput("bit_done", bit_done, expBitDone);
            checkOutput("frame_done", frame_done, expFrameDone);
            checkOutput("Busy", Busy, expBusy);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [PRESCALE_W-1:0] pre, input logic par, input logic stop2);
        Enable   = en;
        Prescale = pre;
        Par_En   = par;
        Stop2    = stop2;
    endtask

    // Counts cycles from startCyc until frame_done, bounded so a stuck DUT still reaches the summary.
    task automatic runFrame(input string name, input int startCyc, input int expCycles, input int expFirstStb, input int expLastBit);
        int cyc = startCyc;
        int firstStb = 0;
        bit seen = 0;
        while (!seen && cyc < 2000) begin
            tick();
            cyc++;
            if (sample_stb && firstStb == 0) firstStb = cyc;
            if (frame_done) seen = 1;
        end
        checkOutput({name, "_frame_cycles"}, cyc, expCycles);
        checkOutput({name, "_first_tap_cycle"}, firstStb, expFirstStb);
        checkOutput({name, "_last_bit"}, bit_count, expLastBit);
    endtask

    task automatic dropEnable();
        Enable = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int fdSeen;
        RST = 1'b1;
        applyStimulus(1'b0, 6'd8, 1'b0, 1'b0);
        tick();
        checkEn = 1'b1;
        tick();
        checkOutput("reset_busy", Busy, 0);
        checkOutput("reset_bit_count", bit_count, 0);
        RST = 1'b0;
        tick();

        // T1: P=8, 10-bit frame
        applyStimulus(1'b1, 6'd8, 1'b0, 1'b0);
        runFrame("t1", 0, 80, 4, 9);
        repeat (3) tick();
        checkOutput("t1_done_busy", Busy, 0);
        dropEnable();

        // T2: P=16 with parity and two stop bits
        applyStimulus(1'b1, 6'd16, 1'b1, 1'b1);
        runFrame("t2", 0, 192, 8, 11);
        dropEnable();

        // T3: prescale change mid-frame is ignored, picked up by the next frame
        applyStimulus(1'b1, 6'd8, 1'b0, 1'b0);
        repeat (25) tick();
        Prescale = 6'd32;
        runFrame("t3a", 25, 80, 28, 9);
        dropEnable();
        applyStimulus(1'b1, 6'd32, 1'b0, 1'b0);
        runFrame("t3b", 0, 320, 16, 9);
        dropEnable();

        // T4: abort at bit 5 edge 2
        applyStimulus(1'b1, 6'd8, 1'b0, 1'b0);
        repeat (43) tick();
        checkOutput("t4_pre_bit", bit_count, 5);
        checkOutput("t4_pre_edge", edge_count, 2);
        Enable = 1'b0;
        tick();
        checkOutput("t4_abort_busy", Busy, 0);
        checkOutput("t4_abort_bit", bit_count, 0);
        fdSeen = 0;
        repeat (100) begin
            tick();
            if (frame_done) fdSeen++;
        end
        checkOutput("t4_no_frame_done", fdSeen, 0);

        // T5: reset mid-frame with Enable held, then a fresh frame
        applyStimulus(1'b1, 6'd8, 1'b0, 1'b0);
        repeat (30) tick();
        RST = 1'b1;
        tick();
        checkOutput("t5_rst_busy", Busy, 0);
        checkOutput("t5_rst_edge", edge_count, 0);
        checkOutput("t5_rst_bit", bit_count, 0);
        RST = 1'b0;
        runFrame("t5", 0, 80, 4, 9);
        dropEnable();

        // T6: prescale 2 and 0 clamp to 4
        applyStimulus(1'b1, 6'd2, 1'b0, 1'b0);
        runFrame("t6a", 0, 40, 2, 9);
        dropEnable();
        applyStimulus(1'b1, 6'd0, 1'b0, 1'b0);
        runFrame("t6b", 0, 40, 2, 9);
        dropEnable();

        repeat (3) tick();
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
